// File: rtl/opb_regbank_pkg.sv
// Shared types and constants for the OPB register bank.
// Word offsets, channel limit, ack FSM state and byte-merge helper.
package opb_regbank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

    localparam int STATUS_WORD = 62;
    localparam int COMMIT_WORD = 63;
    localparam int N_CH_MAX    = 32;

    // be[k] selects word bits [8k+7:8k]
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave front end: window decode, two-state ack FSM and
// capture of address offset, data, byte enables and direction.
module opb_slave_ack
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01094500,
    parameter logic [31:0] C_HIGHADDR = 32'h010945FF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    input  logic        rnw_i,
    input  logic        select_i,
    output logic        ack_o,
    output logic        rnw_o,
    output logic [7:0]  word_o,
    output logic [3:0]  be_o,
    output logic [31:0] data_o
);

    ack_state_e  state_q, state_d;
    logic        hit_w;
    logic [31:0] offs_w;
    logic        unused_offs;
    logic [7:0]  word_q, word_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] data_q, data_d;
    logic        rnw_q, rnw_d;

    assign hit_w = select_i
                && (addr_i >= C_BASEADDR)
                && (addr_i <= C_HIGHADDR);

    assign offs_w      = addr_i - C_BASEADDR;
    assign unused_offs = ^{offs_w[31:10], offs_w[1:0]};

    // hits arriving while in ACK are dropped, not queued
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        be_d    = be_q;
        data_d  = data_q;
        rnw_d   = rnw_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hit_w) begin
                    state_d = ST_ACK;
                    word_d  = offs_w[9:2];
                    be_d    = be_i;
                    data_d  = data_i;
                    rnw_d   = rnw_i;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
            rnw_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            be_q    <= be_d;
            data_q  <= data_d;
            rnw_q   <= rnw_d;
        end
    end

    assign ack_o  = (state_q == ST_ACK);
    assign rnw_o  = rnw_q;
    assign word_o = word_q;
    assign be_o   = be_q;
    assign data_o = data_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank driving user channels, with optional shadow
// staging and atomic commit, plus a commit counter STATUS word.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01094500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010945FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_CH         = 4,
    parameter int          COMMIT_MODE  = 1,
    parameter logic [31:0] RESET_VAL    = 32'h0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [N_CH*32-1:0]        user_data_out,
    output logic                      user_load
);

    localparam int NC = (N_CH > N_CH_MAX) ? N_CH_MAX : N_CH;

    logic [31:0] abus_w;
    logic [3:0]  be_w;
    logic [31:0] dbus_w;
    logic        unused_seq;

    logic        ack_w;
    logic        rnw_w;
    logic [7:0]  word_w;
    logic [3:0]  cbe_w;
    logic [31:0] cdata_w;

    logic [31:0]       stage_q [N_CH];
    logic [31:0]       stage_d [N_CH];
    logic [N_CH*32-1:0] out_q, out_d;
    logic              load_q, load_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              wr_w;
    logic              commit_w;
    logic [31:0]       rdata_w;

    // OPB bit 0 is the MSB: positional copy lands it on bit 31
    assign abus_w     = OPB_ABus;
    assign be_w       = OPB_BE;
    assign dbus_w     = OPB_DBus;
    assign unused_seq = OPB_seqAddr;

    opb_slave_ack #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack (
        .clk_i    (OPB_Clk),
        .rst_ni   (OPB_Rst_n),
        .addr_i   (abus_w),
        .be_i     (be_w),
        .data_i   (dbus_w),
        .rnw_i    (OPB_RNW),
        .select_i (OPB_select),
        .ack_o    (ack_w),
        .rnw_o    (rnw_w),
        .word_o   (word_w),
        .be_o     (cbe_w),
        .data_o   (cdata_w)
    );

    assign wr_w = ack_w && !rnw_w;

    // commit needs the LSB set with its byte lane enabled
    assign commit_w = wr_w
                   && (COMMIT_MODE != 0)
                   && (word_w == 8'(COMMIT_WORD))
                   && cdata_w[0]
                   && cbe_w[0];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            stage_d[i] = stage_q[i];
        end
        out_d  = out_q;
        load_d = 1'b0;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (wr_w) begin
            for (int i = 0; i < NC; i++) begin
                if (word_w == 8'(i)) begin
                    stage_d[i] = be_merge(stage_q[i], cdata_w, cbe_w);
                    if (COMMIT_MODE == 0) begin
                        out_d[32*i +: 32] = stage_d[i];
                        load_d            = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
        end
        if (commit_w) begin
            for (int i = 0; i < N_CH; i++) begin
                out_d[32*i +: 32] = stage_q[i];
            end
            load_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
            out_q  <= {N_CH{RESET_VAL}};
            load_q <= 1'b0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            out_q  <= out_d;
            load_q <= load_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rdata_w = '0;
        for (int i = 0; i < NC; i++) begin
            if (word_w == 8'(i)) begin
                rdata_w = stage_q[i];
            end
        end
        if (word_w == 8'(STATUS_WORD)) begin
            rdata_w = {16'h0, cnt_q, 7'h0, pend_q};
        end
    end

    assign Sl_DBus       = ack_w ? rdata_w : '0;
    assign Sl_xferAck    = ack_w;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = out_q;
    assign user_load     = load_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Scoreboard bench: two banks (shadowed and immediate) on a shared bus.
// Stimulus queues expected acks; a negedge monitor pops and compares.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01094500;
    localparam logic [31:0] RV0  = 32'hA5A50000;

    typedef struct {
        bit          rd;
        logic [31:0] d;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [0:31]  abus;
    logic [0:3]   be;
    logic [0:31]  dbus;
    logic         rnw;
    logic         sel1, sel0;
    logic         seq;

    logic [0:31]  rd1, rd0;
    logic         ack1, ack0;
    logic         err1, ret1, tout1;
    logic         err0, ret0, tout0;
    logic [127:0] udo1, udo0;
    logic         load1, load0;

    exp_t q1[$];
    exp_t q0[$];
    int   checks;
    int   errors;
    int   nload1;

    opb_register_bank_ppc2simulink #(
        .COMMIT_MODE (1),
        .RESET_VAL   (32'h0)
    ) u_dut1 (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel1),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (rd1),
        .Sl_xferAck    (ack1),
        .Sl_errAck     (err1),
        .Sl_retry      (ret1),
        .Sl_toutSup    (tout1),
        .user_data_out (udo1),
        .user_load     (load1)
    );

    opb_register_bank_ppc2simulink #(
        .COMMIT_MODE (0),
        .RESET_VAL   (RV0)
    ) u_dut0 (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel0),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (rd0),
        .Sl_xferAck    (ack0),
        .Sl_errAck     (err0),
        .Sl_retry      (ret0),
        .Sl_toutSup    (tout0),
        .user_data_out (udo0),
        .user_load     (load0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every ack consumes one expectation; idle data must be 0
    always @(negedge clk) begin
        exp_t   e;
        logic [31:0] v1, v0;
        v1 = rd1;
        v0 = rd0;
        if (load1) nload1++;
        if (ack1) begin
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL ack1_unexpected: got ack expected none");
            end else begin
                e = q1.pop_front();
                if (e.rd) chk("rd1_data", 128'(v1), 128'(e.d));
            end
        end else begin
            chk("rd1_idle_zero", 128'(v1), 128'h0);
        end
        if (ack0) begin
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL ack0_unexpected: got ack expected none");
            end else begin
                e = q0.pop_front();
                if (e.rd) chk("rd0_data", 128'(v0), 128'(e.d));
            end
        end else begin
            chk("rd0_idle_zero", 128'(v0), 128'h0);
        end
    end

    task automatic xfer(input int m, input bit rnw_v, input logic [7:0] off,
                        input logic [3:0] be_v, input logic [31:0] d,
                        input logic [31:0] e);
        exp_t x;
        @(posedge clk); #1;
        abus = BASE + {22'h0, off, 2'b00};
        be   = be_v;
        dbus = d;
        rnw  = rnw_v;
        x.rd = rnw_v;
        x.d  = e;
        if (m == 1) begin
            sel1 = 1'b1;
            q1.push_back(x);
        end else begin
            sel0 = 1'b1;
            q0.push_back(x);
        end
        @(posedge clk); #1;
        sel1 = 1'b0;
        sel0 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       x;
        logic [3:0] pat;
        checks = 0;
        errors = 0;
        nload1 = 0;
        rst_n  = 1'b0;
        abus   = '0;
        be     = '0;
        dbus   = '0;
        rnw    = 1'b1;
        sel1   = 1'b0;
        sel0   = 1'b0;
        seq    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack1", 128'(ack1), 128'h0);
        chk("rst_udo1", udo1, 128'h0);
        chk("rst_udo0", udo0, {4{RV0}});
        chk("rst_load", 128'({load1, load0}), 128'h0);
        chk("tied_zero", 128'({err1, ret1, tout1, err0, ret0, tout0}), 128'h0);
        rst_n = 1'b1;

        // shadowed staging then atomic commit
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h0);
        xfer(1, 1'b0, 8'd0, 4'hF, 32'h11223344, 32'h0);
        xfer(1, 1'b0, 8'd1, 4'hF, 32'hAABBCCDD, 32'h0);
        chk("udo1_pre_commit", udo1, 128'h0);
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000001);
        xfer(1, 1'b1, 8'd0, 4'hF, 32'h0, 32'h11223344);
        xfer(1, 1'b0, 8'd63, 4'hF, 32'h00000001, 32'h0);
        chk("udo1_commit", udo1, {64'h0, 32'hAABBCCDD, 32'h11223344});
        @(posedge clk); #1;
        chk("load1_once", 128'(nload1), 128'd1);
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000100);

        // byte-enable merge
        xfer(1, 1'b0, 8'd2, 4'b0101, 32'hFFFFFFFF, 32'h0);
        xfer(1, 1'b1, 8'd2, 4'hF, 32'h0, 32'h00FF00FF);
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000101);

        // select held for 4 cycles on one address
        @(posedge clk); #1;
        abus = BASE;
        rnw  = 1'b1;
        be   = 4'hF;
        sel1 = 1'b1;
        x.rd = 1'b1;
        x.d  = 32'h11223344;
        q1.push_back(x);
        q1.push_back(x);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[3-k] = ack1;
        end
        @(posedge clk); #1;
        sel1 = 1'b0;
        chk("b2b_pattern", 128'(pat), 128'b0101);

        // ineffective commits
        xfer(1, 1'b0, 8'd63, 4'hF, 32'hFFFFFFFE, 32'h0);
        xfer(1, 1'b0, 8'd63, 4'b1110, 32'h00000001, 32'h0);
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000101);

        // counter wrap after 256 commits in total
        for (int n = 0; n < 255; n++) begin
            xfer(1, 1'b0, 8'd63, 4'hF, 32'h00000001, 32'h0);
        end
        @(posedge clk); #1;
        chk("load1_total", 128'(nload1), 128'd256);
        chk("udo1_after_wrap",
            udo1, {32'h0, 32'h00FF00FF, 32'hAABBCCDD, 32'h11223344});
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000000);
        xfer(1, 1'b1, 8'd40, 4'hF, 32'h0, 32'h00000000);
        xfer(1, 1'b0, 8'd62, 4'hF, 32'hFFFFFFFF, 32'h0);
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000000);
        xfer(1, 1'b1, 8'd63, 4'hF, 32'h0, 32'h00000000);

        // immediate mode
        xfer(0, 1'b1, 8'd1, 4'hF, 32'h0, RV0);
        xfer(0, 1'b0, 8'd3, 4'hF, 32'h00000005, 32'h0);
        chk("udo0_ch3", 128'(udo0[127:96]), 128'h5);
        chk("load0_pulse", 128'(load0), 128'h1);
        chk("udo0_low", 128'(udo0[95:0]), 128'({3{RV0}}));
        @(posedge clk); #1;
        chk("load0_drop", 128'(load0), 128'h0);
        xfer(0, 1'b0, 8'd0, 4'b1000, 32'h11111111, 32'h0);
        chk("udo0_ch0_be", 128'(udo0[31:0]), 128'h11A50000);
        xfer(0, 1'b0, 8'd63, 4'hF, 32'h00000001, 32'h0);
        xfer(0, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000000);

        // reset during the ack cycle of a write
        @(posedge clk); #1;
        abus = BASE + 32'h0C;
        be   = 4'hF;
        dbus = 32'h12345678;
        rnw  = 1'b0;
        sel1 = 1'b1;
        @(posedge clk); #1;
        sel1 = 1'b0;
        chk("mid_ack_high", 128'(ack1), 128'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack_drop", 128'(ack1), 128'h0);
        chk("mid_udo1", udo1, 128'h0);
        chk("mid_udo0", udo0, {4{RV0}});
        chk("mid_load", 128'({load1, load0}), 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b1, 8'd3, 4'hF, 32'h0, 32'h00000000);
        xfer(1, 1'b1, 8'd0, 4'hF, 32'h0, 32'h00000000);
        xfer(1, 1'b1, 8'd62, 4'hF, 32'h0, 32'h00000000);
        xfer(0, 1'b1, 8'd3, 4'hF, 32'h0, RV0);

        repeat (3) @(posedge clk);
        #1;
        chk("q1_drained", 128'(q1.size()), 128'h0);
        chk("q0_drained", 128'(q0.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
